// File: rtl/adc_scan_scheduler_if.sv
// Bundles the register-file/BPSM side and the ADC front-end pins of the scan scheduler.
// Latency: none, wiring only.
// Backpressure: none; cmd_req is a level held until cmd_done, results are single-cycle pulses.
interface adc_scan_scheduler_if #(
    parameter int ADC_BITS = 12,
    parameter int MUX_BITS = 4
);
    logic [2:0]             clkdiv;
    logic                   scan_enable;
    logic [2**MUX_BITS-1:0] scan_mask;
    logic                   cmd_req;
    logic [MUX_BITS-1:0]    cmd_mux;
    logic                   cmd_done;
    logic [ADC_BITS-1:0]    cmd_data;
    logic                   res_valid;
    logic [MUX_BITS-1:0]    res_chan;
    logic [ADC_BITS-1:0]    res_data;
    logic                   busy;
    logic                   adc_mux_en;
    logic [MUX_BITS-1:0]    adc_mux_s;
    logic                   adc_cs;
    logic                   adc_clock;
    logic                   adc_data;

    // Scheduler side
    modport slave (
        input  clkdiv, scan_enable, scan_mask, cmd_req, cmd_mux, adc_data,
        output cmd_done, cmd_data, res_valid, res_chan, res_data, busy,
               adc_mux_en, adc_mux_s, adc_cs, adc_clock
    );

    // Requester / pin side
    modport master (
        output clkdiv, scan_enable, scan_mask, cmd_req, cmd_mux, adc_data,
        input  cmd_done, cmd_data, res_valid, res_chan, res_data, busy,
               adc_mux_en, adc_mux_s, adc_cs, adc_clock
    );
endinterface

// File: rtl/adc_scan_scheduler.sv
// Arbitrates the shared ADC front end between one-shot reads and a round-robin background scan.
// Latency: SETTLE_CYCLES + (LEAD_BITS+ADC_BITS)*2*(clkdiv+1) + 2 cycles, counting the grant cycle and the result cycle.
// Backpressure: none; a request waits for the current conversion, results are one-cycle pulses that must be taken.
module adc_scan_scheduler #(
    parameter int ADC_BITS      = 12,
    parameter int LEAD_BITS     = 2,
    parameter int MUX_BITS      = 4,
    parameter int SETTLE_CYCLES = 16
) (
    input  logic              clock,
    input  logic              reset,
    adc_scan_scheduler_if.slave bus
);
    localparam int NCH    = 2**MUX_BITS;
    localparam int N_BITS = LEAD_BITS + ADC_BITS;
    localparam int BCW    = $clog2(N_BITS + 1);
    localparam int SCW    = $clog2(SETTLE_CYCLES + 1);

    typedef enum logic [1:0] {S_IDLE, S_SELECT, S_CONV, S_DONE} state_t;

    state_t              r_state;
    state_t              w_next;

    logic [MUX_BITS-1:0] r_chan;
    logic                r_own_cmd;
    logic [MUX_BITS-1:0] r_scan_ptr;     // first candidate for the next scan grant
    logic [SCW-1:0]      r_settle;
    logic [2:0]          r_div;
    logic [2:0]          r_div_cnt;
    logic                r_sclk;
    logic [BCW-1:0]      r_bit_cnt;
    logic [ADC_BITS-1:0] r_shift;
    logic                r_cmd_done;
    logic [ADC_BITS-1:0] r_cmd_data;
    logic                r_res_valid;
    logic [MUX_BITS-1:0] r_res_chan;
    logic [ADC_BITS-1:0] r_res_data;

    logic                w_scan_hit;
    logic [MUX_BITS-1:0] w_scan_chan;
    logic [MUX_BITS-1:0] w_idx;
    logic                w_grant_cmd;
    logic                w_grant_scan;
    logic                w_settle_done;
    logic                w_half_end;
    logic                w_conv_last;

    // Find the first enabled channel at or after the scan pointer, wrapping around
    always_comb begin
        w_scan_hit  = 1'b0;
        w_scan_chan = '0;
        w_idx       = '0;
        // Walk from the far end back so the nearest hit is the one left standing
        for (int i = NCH - 1; i >= 0; i--) begin
            w_idx = r_scan_ptr + MUX_BITS'(i);
            if (bus.scan_mask[w_idx]) begin
                w_scan_hit  = 1'b1;
                w_scan_chan = w_idx;
            end
        end
    end

    // One-shot reads always win over the scan in IDLE
    assign w_grant_cmd   = (r_state == S_IDLE) && bus.cmd_req;
    assign w_grant_scan  = (r_state == S_IDLE) && !bus.cmd_req && bus.scan_enable && w_scan_hit;
    assign w_settle_done = (r_settle == '0);
    assign w_half_end    = (r_div_cnt == 3'd0);
    assign w_conv_last   = (r_state == S_CONV) && w_half_end && r_sclk &&
                           (r_bit_cnt == BCW'(N_BITS - 1));

    // State register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    // Next-state decode
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (w_grant_cmd || w_grant_scan) w_next = S_SELECT;
            S_SELECT: if (w_settle_done) w_next = S_CONV;
            S_CONV:   if (w_conv_last) w_next = S_DONE;
            S_DONE:   w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    // Grant capture, scan pointer and mux settling countdown
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_chan     <= '0;
            r_own_cmd  <= 1'b0;
            r_scan_ptr <= '0;
            r_settle   <= '0;
        end else begin
            if (w_grant_cmd) begin
                r_chan    <= bus.cmd_mux;
                r_own_cmd <= 1'b1;
                r_settle  <= SCW'(SETTLE_CYCLES - 1);
            end else if (w_grant_scan) begin
                r_chan     <= w_scan_chan;
                r_own_cmd  <= 1'b0;
                r_scan_ptr <= w_scan_chan + MUX_BITS'(1);
                r_settle   <= SCW'(SETTLE_CYCLES - 1);
            end else if (r_state == S_SELECT && !w_settle_done) begin
                r_settle <= r_settle - SCW'(1);
            end
        end
    end

    // Serial clock generation and MSB-first shift-in of the ADC word
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_div     <= '0;
            r_div_cnt <= '0;
            r_sclk    <= 1'b0;
            r_bit_cnt <= '0;
            r_shift   <= '0;
        end else if (r_state == S_SELECT && w_settle_done) begin
            // clkdiv is frozen for the whole conversion
            r_div     <= bus.clkdiv;
            r_div_cnt <= bus.clkdiv;
            r_sclk    <= 1'b0;
            r_bit_cnt <= '0;
            r_shift   <= '0;
        end else if (r_state == S_CONV) begin
            if (w_half_end) begin
                r_div_cnt <= r_div;
                if (!r_sclk) begin
                    r_sclk <= 1'b1;
                    // Sample on the rising edge; leading null bits are dropped
                    if (r_bit_cnt >= BCW'(LEAD_BITS))
                        r_shift <= {r_shift[ADC_BITS-2:0], bus.adc_data};
                end else begin
                    r_sclk    <= 1'b0;
                    r_bit_cnt <= r_bit_cnt + BCW'(1);
                end
            end else begin
                r_div_cnt <= r_div_cnt - 3'd1;
            end
        end
    end

    // Result pulses, routed to the owner of the grant; data held between pulses
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_cmd_done  <= 1'b0;
            r_cmd_data  <= '0;
            r_res_valid <= 1'b0;
            r_res_chan  <= '0;
            r_res_data  <= '0;
        end else begin
            r_cmd_done  <= w_conv_last && r_own_cmd;
            r_res_valid <= w_conv_last && !r_own_cmd;
            if (w_conv_last && r_own_cmd) r_cmd_data <= r_shift;
            if (w_conv_last && !r_own_cmd) begin
                r_res_chan <= r_chan;
                r_res_data <= r_shift;
            end
        end
    end

    assign bus.busy       = (r_state != S_IDLE);
    assign bus.adc_mux_en = (r_state != S_IDLE);
    assign bus.adc_mux_s  = r_chan;
    assign bus.adc_cs     = (r_state != S_CONV);
    assign bus.adc_clock  = r_sclk;
    assign bus.cmd_done   = r_cmd_done;
    assign bus.cmd_data   = r_cmd_data;
    assign bus.res_valid  = r_res_valid;
    assign bus.res_chan   = r_res_chan;
    assign bus.res_data   = r_res_data;

endmodule

// File: doc/adc_scan_scheduler.md
Name: adc_scan_scheduler

Overview:
Sequences the shared external ADC front end: analog mux enable/select, settling delay and serial ADC readout (adc_cs, adc_clock, adc_data). Arbitrates one resource between two requesters. The bus pirate state machine issues one-shot reads (CMD_ADC_READ), and a background round-robin scan covers all channels enabled in a mask. Sits between the BPSM/register file and the adc_* top-level pins.

Parameters:
ADC_BITS, 12, result width; data bits shifted MSB-first.
LEAD_BITS, 2, null bits clocked out before MSB and discarded.
MUX_BITS, 4, analog mux select width (2**MUX_BITS channels).
SETTLE_CYCLES, 16, clock cycles of mux settling before conversion (>=1).

Ports:
clock  in  1  system clock
reset  in  1  asynchronous, active-high reset
clkdiv  in  3  adc_clock half-period = clkdiv+1 clock cycles; latched at conversion start
scan_enable  in  1  background scan enable (level)
scan_mask  in  2**MUX_BITS  channel enable bits for background scan
cmd_req  in  1  one-shot read request (level, held until cmd_done)
cmd_mux  in  MUX_BITS  channel for one-shot read; latched on acceptance
cmd_done  out  1  one-cycle pulse, cmd_data valid
cmd_data  out  ADC_BITS  one-shot result, held until next cmd_done
res_valid  out  1  one-cycle pulse, scan result valid
res_chan  out  MUX_BITS  channel of scan result
res_data  out  ADC_BITS  scan result, held until next res_valid
busy  out  1  high in any state except IDLE
adc_mux_en  out  1  analog mux enable
adc_mux_s  out  MUX_BITS  analog mux select
adc_cs  out  1  ADC chip select, active low
adc_clock  out  1  ADC serial clock, idles low
adc_data  in  1  ADC serial data

Behaviour:
- Reset (async): state IDLE; adc_cs=1, adc_clock=0, adc_mux_en=0, adc_mux_s=0, cmd_done=0, res_valid=0, cmd_data=0, res_data=0, res_chan=0, busy=0, scan pointer=0. Reset mid-conversion aborts immediately with no result pulse.
- States: IDLE -> SELECT -> CONV -> DONE -> IDLE.
- IDLE arbitration, evaluated each cycle:
  - cmd_req=1 wins and latches cmd_mux.
  - Otherwise, if scan_enable=1 and scan_mask!=0, select the next set mask bit strictly after the last scanned channel, wrapping modulo 2**MUX_BITS. After reset the first candidate is channel 0.
  - Otherwise stay in IDLE.
  - The scan pointer advances only on scan grants.
- SELECT: adc_mux_en=1 and adc_mux_s=channel for exactly SETTLE_CYCLES cycles, adc_cs=1. adc_mux_en and adc_mux_s are held through CONV and DONE. adc_mux_en returns to 0 in IDLE; adc_mux_s keeps its last value.
- CONV:
  - clkdiv is latched on entry and adc_cs=0.
  - N = LEAD_BITS+ADC_BITS adc_clock periods. Each period is clkdiv+1 cycles low, then clkdiv+1 cycles high.
  - adc_data is sampled in the cycle adc_clock drives 0->1.
  - The first LEAD_BITS samples are discarded; the remaining samples are shifted in MSB-first.
  - The state ends after the last high phase, with adc_clock back at 0.
- DONE: one cycle. adc_cs=1, adc_clock=0. Pulse cmd_done with cmd_data, or res_valid with res_chan/res_data, according to the owner of the grant.
- Latency: cmd_done asserts SETTLE_CYCLES + N*2*(clkdiv+1) + 2 cycles after the cycle cmd_req is sampled in IDLE. Defaults with clkdiv=3 give 16+112+2 = 130.
- No preemption: a request arriving during a scan conversion waits; it is granted in the first IDLE cycle, ahead of further scans.
- cmd_req still high in the cycle after cmd_done counts as a new request (back-to-back reads allowed).
- scan_enable deasserted or scan_mask changed mid-conversion: the current conversion completes and reports normally; the new mask applies at the next IDLE arbitration.
- Single-bit scan_mask: the same channel repeats. Scan and command results never share an output.

Test Plan:
1. Reset, clkdiv=3, cmd_mux=4'h1, cmd_req=1, ADC model returns 2'b00 then 12'hA5C -> adc_mux_s=1; adc_cs low for 112 cycles; 14 rising adc_clock edges; cmd_done pulse at cycle 130 with cmd_data=12'hA5C; no res_valid.
2. scan_enable=1, scan_mask=16'h0105 -> res_chan sequence 0,2,8,0,2; each res_data matches the model value for that channel; adc_mux_en low in every IDLE gap.
3. During the scan of channel 2, cmd_req=1 with cmd_mux=4'hF -> the channel 2 scan completes, then channel 15 converts and cmd_done fires, then the scan resumes at channel 8.
4. Assert reset midway through CONV -> adc_cs=1, adc_clock=0, adc_mux_en=0 asynchronously, with no cmd_done or res_valid; the next command after reset completes normally.
5. clkdiv=0 and clkdiv=7 with ADC_BITS=12 -> adc_clock half-periods of 1 and 8 cycles; cmd_done latency of 16+28+2=46 and 16+224+2=242 cycles.
6. scan_enable=1 with scan_mask=0 -> busy stays 0 and adc_cs stays 1 indefinitely.
